// File: rtl/clkdiv_pkg.sv
// Purpose : shared types and defaults for the multi-channel clock divider.
// Latency : n/a (package only).
// Backpressure: n/a; free-running dividers have no flow control.
package clkdiv_pkg;

   // Per-channel FSM encoding.
   localparam logic CLKDIV_ST_IDLE = 1'b0;
   localparam logic CLKDIV_ST_RUN  = 1'b1;

   // Default build dimensions.
   localparam int CLKDIV_WIDTH    = 32;
   localparam int CLKDIV_CHANNELS = 4;

   typedef enum logic {
      ST_IDLE = CLKDIV_ST_IDLE,
      ST_RUN  = CLKDIV_ST_RUN
   } clkdiv_state_t;

endpackage

// File: rtl/clkdiv_channel.sv
// Purpose : one divider channel; counter, shadow half-period register and IDLE/RUN FSM.
// Latency : clk_div first rises num cycles after entering RUN, then toggles every act_num cycles.
// Backpressure: none; en low or sync restarts the channel immediately.
//
// Ports: clk, rst (sync, active-high), en (run enable), sync (phase-align restart),
//        num (half-period in clk cycles), clk_div (divided clock, registered),
//        tick (1-cycle pulse on the clk_div 0->1 edge; present only with CLKDIV_TICK_EN).
module clkdiv_channel
   import clkdiv_pkg::*;
#(
   parameter int WIDTH = CLKDIV_WIDTH
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic [WIDTH-1:0] num,
   output logic             clk_div
`ifdef CLKDIV_TICK_EN
   ,
   output logic             tick
`endif
);

   clkdiv_state_t    state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] act_q, act_d;
   logic             clk_div_d;
   logic             num_nz;
   logic             last;

   assign num_nz = (num != '0);
   // act_q is never 0 in RUN, so act_q-1 cannot wrap and even the maximum
   // half-period compares without a wider counter.
   assign last   = (cnt_q == (act_q - WIDTH'(1)));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      act_d     = act_q;
      clk_div_d = clk_div;

      if (sync) begin
         // Common restart: every channel goes low with a cleared counter so
         // channels with equal num produce coincident edges afterwards.
         cnt_d     = '0;
         clk_div_d = 1'b0;
         if (en && num_nz) begin
            act_d   = num;
            state_d = ST_RUN;
         end else begin
            state_d = ST_IDLE;
         end
      end else if (!en) begin
         state_d   = ST_IDLE;
         cnt_d     = '0;
         clk_div_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d     = '0;
               clk_div_d = 1'b0;
               if (num_nz) begin
                  act_d   = num;
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (last) begin
                  // Period boundary: the only place num is taken, so a
                  // half-period in flight is never shortened.
                  cnt_d = '0;
                  act_d = num;
                  if (num_nz) begin
                     clk_div_d = ~clk_div;
                  end else begin
                     state_d   = ST_IDLE;
                     clk_div_d = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q + WIDTH'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         act_q   <= '0;
         clk_div <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         act_q   <= act_d;
         clk_div <= clk_div_d;
      end
   end

`ifdef CLKDIV_TICK_EN
   // Derived from the next clk_div value, so sync / en-low / num==0 paths
   // (which all force clk_div_d low) can never emit a tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick <= 1'b0;
      end else begin
         tick <= clk_div_d & ~clk_div;
      end
   end
`endif

endmodule

// File: rtl/multi_clock_divider.sv
// Purpose : CHANNELS independent clock dividers sharing clk, rst and a phase-align sync.
// Latency : all outputs registered; channel i first rises num_i cycles after entering RUN.
// Backpressure: none; channels free-run while enabled.
//
// Ports: clk, rst (sync, active-high), en[CHANNELS], sync (1-cycle restart pulse),
//        num[CHANNELS*WIDTH] (channel i = num[i*WIDTH +: WIDTH]), clk_div[CHANNELS],
//        tick[CHANNELS] (only when the CLKDIV_TICK_EN macro is defined).
module multi_clock_divider
   import clkdiv_pkg::*;
#(
   parameter int CHANNELS = CLKDIV_CHANNELS,
   parameter int WIDTH    = CLKDIV_WIDTH
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       en,
   input  logic                      sync,
   input  logic [CHANNELS*WIDTH-1:0] num,
   output logic [CHANNELS-1:0]       clk_div
`ifdef CLKDIV_TICK_EN
   ,
   output logic [CHANNELS-1:0]       tick
`endif
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      clkdiv_channel #(
         .WIDTH (WIDTH)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .en      (en[i]),
         .sync    (sync),
         .num     (num[i*WIDTH +: WIDTH]),
         .clk_div (clk_div[i])
`ifdef CLKDIV_TICK_EN
         ,
         .tick    (tick[i])
`endif
      );
   end

endmodule
